// File: rtl/avln_pkt_gen_pkg.sv
// global_types: shared stream types, beat geometry and the packet generator state enum
package global_types;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned EMPTY_W = $clog2(BYTES);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic sop;
    logic eop;
    logic [EMPTY_W-1:0] empty;
    logic valid;
  } avln_st;
  typedef enum logic [1:0] {IDLE, SEND, GAP} gen_state_e;
  function automatic int unsigned beats_of(input int unsigned len);
    return (len + BYTES - 1) / BYTES;
  endfunction
endpackage

// File: rtl/avln_beat_fmt.sv
// avln_beat_fmt: formats one beat of the self-checking payload and its framing flags
module avln_beat_fmt
  import global_types::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [15:0]        beat_idx,
  input  logic [LEN_W-1:0]   beats_left,
  input  logic [15:0]        pkt_seq,
  input  logic [LEN_W-1:0]   len,
  output logic [DATA_W-1:0]  data,
  output logic               sop,
  output logic               eop,
  output logic [EMPTY_W-1:0] empty
);
  logic [EMPTY_W-1:0] rem;
  assign rem = len[EMPTY_W-1:0];
  assign sop = beat_idx == 16'd0;
  assign eop = beats_left == LEN_W'(1);
  // with a power-of-two beat width, (B - len mod B) mod B is just -len mod B
  assign empty = eop ? EMPTY_W'(-rem) : '0;
  assign data = {pkt_seq, beat_idx, ~pkt_seq, ~beat_idx};
endmodule

// File: rtl/avln_pkt_gen.sv
// avln_pkt_gen: Avalon-ST packet generator with run control, inter-packet gap and stop
module avln_pkt_gen
  import global_types::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] num_pkts,
  output avln_st           out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_count
);
  gen_state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, left_q, left_d, len_sel;
  logic [GAP_W-1:0] gap_q, gcnt_q, gcnt_d;
  logic [CNT_W-1:0] num_q, cnt_q, cnt_d, seq_q, seq_d;
  logic [15:0] idx_q, idx_d;
  logic stop_q, stop_d, done_q, take, mid, eop_now, fin, nxt, emit;
  avln_st out_q, out_d;
  logic [DATA_W-1:0] f_data;
  logic f_sop, f_eop;
  logic [EMPTY_W-1:0] f_empty;
  always_comb begin
    take = state_q == IDLE && start && pkt_len != '0;
    len_sel = take ? pkt_len : len_q;
    stop_d = state_q != IDLE && (stop_q || stop);
    mid = state_q == SEND && left_q != LEN_W'(1);
    eop_now = state_q == SEND && left_q == LEN_W'(1);
    cnt_d = take ? '0 : cnt_q + CNT_W'(eop_now);
    fin = (eop_now && (stop_d || (num_q != '0 && cnt_d == num_q))) || (state_q == GAP && stop_d);
    nxt = (eop_now && gap_q == '0) || (state_q == GAP && gcnt_q == GAP_W'(1));
    emit = take || mid || (nxt && !fin);
    idx_d = mid ? idx_q + 16'd1 : 16'd0;
    left_d = mid ? left_q - LEN_W'(1) : LEN_W'(beats_of(32'(len_sel)));
    seq_d = mid ? seq_q : cnt_d;
    gcnt_d = state_q == GAP ? gcnt_q - GAP_W'(1) : gap_q;
    state_d = fin ? IDLE : emit ? SEND : state_q == SEND ? GAP : state_q;
    out_d = emit ? avln_st'{data: f_data, sop: f_sop, eop: f_eop, empty: f_empty, valid: 1'b1} : '0;
  end
  avln_beat_fmt #(.LEN_W(LEN_W)) u_fmt (
    .beat_idx  (idx_d),
    .beats_left(left_d),
    .pkt_seq   (16'(seq_d)),
    .len       (len_sel),
    .data      (f_data),
    .sop       (f_sop),
    .eop       (f_eop),
    .empty     (f_empty)
  );
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q <= '0;
      done_q <= 1'b0;
      cnt_q <= '0;
      seq_q <= '0;
      idx_q <= '0;
      left_q <= '0;
      gcnt_q <= '0;
      stop_q <= 1'b0;
      len_q <= '0;
      gap_q <= '0;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      done_q <= fin;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      idx_q <= idx_d;
      left_q <= left_d;
      gcnt_q <= gcnt_d;
      stop_q <= stop_d;
      if (take) begin
        len_q <= pkt_len;
        gap_q <= gap;
        num_q <= num_pkts;
      end
    end
  end
  assign out = out_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign pkt_count = cnt_q;
endmodule
